// File: rtl/zx_cart_mapper.sv
// rtl/zx_cart_mapper.sv - ZX cartridge bank mapper: port-0x7F bank select, self-lock, readback
module zx_cart_mapper #(
   parameter int BANK_W        = 6,
   parameter int MODE          = 0,
   parameter int SELF_LOCK_VAL = 10,
   parameter int RESET_BANK    = 0,
   parameter int SYNC_STAGES   = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              iorq_n,
   input  logic              rd_n,
   input  logic              wr_n,
   input  logic              mreq_n,
   input  logic              m1_n,
   input  logic              A7,
   input  logic              A13,
   input  logic              A14,
   input  logic              A15,
   input  logic [7:0]        D_in,
   output logic [7:0]        D_out,
   output logic              D_oe,
   output logic              ZX_ROM_blk,
   output logic              CR_ROM_oe_n,
   output logic [BANK_W-1:0] CR_ROM_A,
   output logic              locked
);

   localparam logic [BANK_W-1:0] RESET_BANK_V = BANK_W'(RESET_BANK);
   localparam logic [6:0]        RESET_EXT    = 7'(RESET_BANK);

   logic [SYNC_STAGES-1:0]      iorq_p, rd_p, wr_p, m1_p, a7_p, fill;
   logic [SYNC_STAGES-1:0][7:0] d_p;
   logic                        iorq_s, rd_s, wr_s, m1_s, a7_s;
   logic [7:0]                  d_s;
   logic                        acc, acc_wr, acc_prev, evt, lock_hit;
   logic [BANK_W-1:0]           bank;
   logic [6:0]                  bank_ext;
   logic                        unused_d;

   assign iorq_s = iorq_p[SYNC_STAGES-1];
   assign rd_s   = rd_p[SYNC_STAGES-1];
   assign wr_s   = wr_p[SYNC_STAGES-1];
   assign m1_s   = m1_p[SYNC_STAGES-1];
   assign a7_s   = a7_p[SYNC_STAGES-1];
   assign d_s    = d_p[SYNC_STAGES-1];
   assign unused_d = &{1'b0, d_s};

   assign acc      = ~iorq_s & m1_s & ~a7_s & (~rd_s | ~wr_s);
   assign acc_wr   = acc & ~wr_s;
   assign evt      = acc & ~acc_prev;
   assign lock_hit = (32'(bank) == SELF_LOCK_VAL);

   always_comb begin
      bank_ext = '0;
      bank_ext[BANK_W-1:0] = bank;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         iorq_p   <= '1;
         rd_p     <= '1;
         wr_p     <= '1;
         m1_p     <= '1;
         a7_p     <= '1;
         d_p      <= '1;
         fill     <= '0;
         acc_prev <= 1'b1;
         bank     <= RESET_BANK_V;
         locked   <= 1'b0;
         D_out    <= {1'b0, RESET_EXT};
      end else begin
         iorq_p <= {iorq_p[SYNC_STAGES-2:0], iorq_n};
         rd_p   <= {rd_p[SYNC_STAGES-2:0], rd_n};
         wr_p   <= {wr_p[SYNC_STAGES-2:0], wr_n};
         m1_p   <= {m1_p[SYNC_STAGES-2:0], m1_n};
         a7_p   <= {a7_p[SYNC_STAGES-2:0], A7};
         d_p    <= {d_p[SYNC_STAGES-2:0], D_in};
         fill   <= {fill[SYNC_STAGES-2:0], 1'b1};
         // Keep acc_prev high until the synchronisers have refilled, so a cycle
         // already in progress at reset release never looks like a new access.
         acc_prev <= acc | ~fill[SYNC_STAGES-1];
         if (evt && !locked) begin
            if (MODE == 0) begin
               bank <= bank + BANK_W'(1);
               if (lock_hit)
                  locked <= 1'b1;
            end else if (acc_wr) begin
               bank <= d_s[BANK_W-1:0];
               if (d_s[7])
                  locked <= 1'b1;
            end
         end
         D_out <= {locked, bank_ext};
      end
   end

   // Read-side enables come straight from the raw bus to fit the CPU read window.
   assign D_oe        = (MODE == 1) & ~iorq_n & m1_n & ~rd_n & ~A7 & ~locked;
   assign CR_ROM_oe_n = A15 | A14 | A13 | rd_n | mreq_n | locked;
   assign ZX_ROM_blk  = ~CR_ROM_oe_n;
   assign CR_ROM_A    = bank;

endmodule

// File: tb/tb_zx_cart_mapper.sv
// tb/tb_zx_cart_mapper.sv - bench for zx_cart_mapper: vector table, corner sequences, random vs model
module tb_zx_cart_mapper;

   logic clk = 1'b0;
   logic reset_n, iorq_n, rd_n, wr_n, mreq_n, m1_n, A7, A13, A14, A15;
   logic [7:0] D_in;

   logic [7:0] d_out0, d_out1, d_out2;
   logic       d_oe0, d_oe1, d_oe2, blk0, blk1, blk2, oe_n0, oe_n1, oe_n2, lk0, lk1, lk2;
   logic [5:0] a0, a2;
   logic [2:0] a1;

   int checks = 0;
   int errors = 0;

   int m_b0, m_b1, m_b2;
   bit m_l0, m_l1, m_l2;

   always #5 clk = ~clk;

   zx_cart_mapper u0 (
      .clk(clk), .reset_n(reset_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .mreq_n(mreq_n), .m1_n(m1_n), .A7(A7), .A13(A13), .A14(A14), .A15(A15),
      .D_in(D_in), .D_out(d_out0), .D_oe(d_oe0), .ZX_ROM_blk(blk0),
      .CR_ROM_oe_n(oe_n0), .CR_ROM_A(a0), .locked(lk0));

   zx_cart_mapper #(.BANK_W(3), .SELF_LOCK_VAL(20)) u1 (
      .clk(clk), .reset_n(reset_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .mreq_n(mreq_n), .m1_n(m1_n), .A7(A7), .A13(A13), .A14(A14), .A15(A15),
      .D_in(D_in), .D_out(d_out1), .D_oe(d_oe1), .ZX_ROM_blk(blk1),
      .CR_ROM_oe_n(oe_n1), .CR_ROM_A(a1), .locked(lk1));

   zx_cart_mapper #(.MODE(1)) u2 (
      .clk(clk), .reset_n(reset_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .mreq_n(mreq_n), .m1_n(m1_n), .A7(A7), .A13(A13), .A14(A14), .A15(A15),
      .D_in(D_in), .D_out(d_out2), .D_oe(d_oe2), .ZX_ROM_blk(blk2),
      .CR_ROM_oe_n(oe_n2), .CR_ROM_A(a2), .locked(lk2));

   typedef struct {
      bit         a7;
      bit         wr;
      bit         m1n;
      logic [7:0] data;
      int         hold;
      int         e0;
      bit         l0;
      int         e1;
      int         e2;
      bit         l2;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_b0 = 0; m_b1 = 0; m_b2 = 0;
      m_l0 = 0; m_l1 = 0; m_l2 = 0;
   endtask

   // One complete port access applied to the spec-level bank/lock rules.
   task automatic model_io(input bit a7, input bit wr, input bit m1n, input logic [7:0] data);
      if (!a7 && m1n) begin
         if (!m_l0) begin
            if (m_b0 == 10) m_l0 = 1;
            m_b0 = (m_b0 + 1) % 64;
         end
         if (!m_l1) begin
            if (m_b1 == 20) m_l1 = 1;
            m_b1 = (m_b1 + 1) % 8;
         end
         if (wr && !m_l2) begin
            m_b2 = data % 64;
            m_l2 = data[7];
         end
      end
   endtask

   task automatic bus_idle();
      iorq_n = 1; rd_n = 1; wr_n = 1; mreq_n = 1; m1_n = 1;
      A7 = 1; A13 = 1; A14 = 1; A15 = 1; D_in = 8'h00;
   endtask

   task automatic io_cycle(input bit a7, input bit wr, input bit m1n,
                           input logic [7:0] data, input int hold);
      bit exp_oe;
      @(negedge clk);
      A7 = a7; D_in = data; m1_n = m1n;
      iorq_n = 0; rd_n = wr; wr_n = !wr;
      repeat (hold) @(negedge clk);
      #1;
      if (!wr) begin
         exp_oe = !a7 && m1n && !m_l2;
         chk("u2_d_oe", int'(d_oe2), int'(exp_oe));
         if (exp_oe)
            chk("u2_d_out", int'(d_out2), (int'(m_l2) << 7) | m_b2);
         chk("u0_d_oe", int'(d_oe0), 0);
      end
      bus_idle();
      repeat (5) @(negedge clk);
      model_io(a7, wr, m1n, data);
   endtask

   task automatic cmp_all(input string tag);
      #1;
      chk({tag, "_bank0"}, int'(a0), m_b0);
      chk({tag, "_lock0"}, int'(lk0), int'(m_l0));
      chk({tag, "_bank1"}, int'(a1), m_b1);
      chk({tag, "_lock1"}, int'(lk1), int'(m_l1));
      chk({tag, "_bank2"}, int'(a2), m_b2);
      chk({tag, "_lock2"}, int'(lk2), int'(m_l2));
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus_idle();
      reset_n = 0;
      repeat (2) @(negedge clk);
      reset_n = 1;
      repeat (2) @(negedge clk);
      model_reset();
   endtask

   task automatic mem_chk();
      bit base;
      @(negedge clk);
      {A15, A14, A13} = 3'($urandom_range(0, 7) & ($urandom_range(0, 1) ? 7 : 0));
      rd_n   = ($urandom_range(0, 3) == 0);
      mreq_n = ($urandom_range(0, 3) == 0);
      #1;
      base = A15 | A14 | A13 | rd_n | mreq_n;
      chk("mem_oe_n0", int'(oe_n0), int'(base | m_l0));
      chk("mem_blk0", int'(blk0), int'(!(base | m_l0)));
      chk("mem_oe_n2", int'(oe_n2), int'(base | m_l2));
      chk("mem_blk2", int'(blk2), int'(!(base | m_l2)));
      bus_idle();
   endtask

   initial begin
      logic [7:0] rdata;
      int kind;

      tbl[0]  = '{0, 0, 1, 8'h00, 4,   1, 0, 1,  0, 0};
      tbl[1]  = '{0, 0, 1, 8'h00, 4,   2, 0, 2,  0, 0};
      tbl[2]  = '{0, 0, 0, 8'h00, 4,   2, 0, 2,  0, 0};
      tbl[3]  = '{1, 0, 1, 8'h00, 4,   2, 0, 2,  0, 0};
      tbl[4]  = '{0, 1, 1, 8'h2A, 4,   3, 0, 3, 42, 0};
      tbl[5]  = '{0, 0, 1, 8'h00, 20,  4, 0, 4, 42, 0};
      tbl[6]  = '{0, 1, 1, 8'h11, 4,   5, 0, 5, 17, 0};
      tbl[7]  = '{0, 0, 1, 8'h00, 4,   6, 0, 6, 17, 0};
      tbl[8]  = '{0, 0, 1, 8'h00, 4,   7, 0, 7, 17, 0};
      tbl[9]  = '{0, 1, 1, 8'h3F, 4,   8, 0, 0, 63, 0};
      tbl[10] = '{0, 0, 1, 8'h00, 4,   9, 0, 1, 63, 0};
      tbl[11] = '{0, 0, 1, 8'h00, 4,  10, 0, 2, 63, 0};
      tbl[12] = '{0, 0, 1, 8'h00, 4,  11, 1, 3, 63, 0};
      tbl[13] = '{0, 1, 1, 8'h85, 4,  11, 1, 4,  5, 1};
      tbl[14] = '{0, 1, 1, 8'h2A, 4,  11, 1, 5,  5, 1};
      tbl[15] = '{0, 0, 1, 8'h00, 4,  11, 1, 6,  5, 1};

      bus_idle();
      reset_n = 1;
      model_reset();

      // Reset held while an access is in progress: no event until IORQ toggles.
      @(negedge clk);
      iorq_n = 0; rd_n = 0; A7 = 0; m1_n = 1;
      reset_n = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_bank0", int'(a0), 0);
      chk("rst_lock0", int'(lk0), 0);
      reset_n = 1;
      repeat (8) @(negedge clk);
      cmp_all("rst_hold");
      bus_idle();
      repeat (5) @(negedge clk);
      cmp_all("rst_release");
      io_cycle(0, 0, 1, 8'h00, 4);
      chk("rst_first_inc", int'(a0), 1);

      // Vector table.
      do_reset();
      cmp_all("tbl_start");
      for (int i = 0; i < 16; i++) begin
         io_cycle(tbl[i].a7, tbl[i].wr, tbl[i].m1n, tbl[i].data, tbl[i].hold);
         #1;
         chk($sformatf("tbl%0d_bank0", i), int'(a0), tbl[i].e0);
         chk($sformatf("tbl%0d_lock0", i), int'(lk0), int'(tbl[i].l0));
         chk($sformatf("tbl%0d_bank1", i), int'(a1), tbl[i].e1);
         chk($sformatf("tbl%0d_lock1", i), int'(lk1), 0);
         chk($sformatf("tbl%0d_bank2", i), int'(a2), tbl[i].e2);
         chk($sformatf("tbl%0d_lock2", i), int'(lk2), int'(tbl[i].l2));
      end
      @(negedge clk);
      A15 = 0; A14 = 0; A13 = 0; rd_n = 0; mreq_n = 0;
      #1;
      chk("locked_oe_n0", int'(oe_n0), 1);
      chk("locked_blk0", int'(blk0), 0);
      bus_idle();

      // Five port reads then lower-ROM reads inside and outside the window.
      do_reset();
      for (int i = 0; i < 5; i++) io_cycle(0, 0, 1, 8'h00, 4);
      @(negedge clk);
      A15 = 0; A14 = 0; A13 = 0; rd_n = 0; mreq_n = 0;
      #1;
      chk("mem_bank5", int'(a0), 5);
      chk("mem_0100_oe_n", int'(oe_n0), 0);
      chk("mem_0100_blk", int'(blk0), 1);
      @(negedge clk);
      A13 = 1;
      #1;
      chk("mem_2000_oe_n", int'(oe_n0), 1);
      chk("mem_2000_blk", int'(blk0), 0);
      bus_idle();

      // Reset pulsed in the middle of a long access.
      do_reset();
      for (int i = 0; i < 3; i++) io_cycle(0, 0, 1, 8'h00, 4);
      @(negedge clk);
      iorq_n = 0; rd_n = 0; A7 = 0; m1_n = 1;
      repeat (5) @(negedge clk);
      reset_n = 0;
      repeat (2) @(negedge clk);
      reset_n = 1;
      repeat (8) @(negedge clk);
      bus_idle();
      repeat (5) @(negedge clk);
      model_reset();
      cmp_all("mid_rst");

      // Random accesses against the model.
      for (int r = 0; r < 4; r++) begin
         do_reset();
         for (int n = 0; n < 25; n++) begin
            kind  = int'($urandom_range(0, 9));
            rdata = 8'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) rdata = rdata | 8'h80;
            case (kind)
               0:       io_cycle(1, $urandom_range(0, 1), 1, rdata, 3 + $urandom_range(0, 6));
               1:       io_cycle(0, 0, 0, rdata, 3 + $urandom_range(0, 6));
               2, 3, 4: io_cycle(0, 1, 1, rdata, 3 + $urandom_range(0, 6));
               default: io_cycle(0, 0, 1, rdata, 3 + $urandom_range(0, 6));
            endcase
            cmp_all($sformatf("rnd%0d_%0d", r, n));
            mem_chk();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
